// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding, strobe width masks, trap codes, commit bundle and alignment helpers
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT = 4'd7;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_w_en;
    logic [4:0]  reg_w_rd;
    logic [31:0] reg_w_data;
    logic        csr_w_en;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        jmp_do;
    logic [31:0] jmp_pc;
    logic        chmode_do;
    logic [1:0]  chmode_to;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
  } wb_t;
  function automatic logic [3:0] norm_strb(input logic [3:0] s);
    return (s == STRB_BYTE || s == STRB_HALF) ? s : STRB_WORD;
  endfunction
  function automatic logic misaligned(input logic [3:0] w, input logic [1:0] lo);
    return (w == STRB_HALF && lo == 2'd3) || (w == STRB_WORD && lo != 2'd0);
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: extracts the addressed byte/half/word lane from rdata and zero- or sign-extends it to 32 bits
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  strb,
  input  logic        is_signed,
  output logic [31:0] data
);
  logic [31:0] s;
  assign s = rdata >> {addr, 3'b000};
  assign data = strb == STRB_BYTE ? {{24{is_signed & s[7]}}, s[7:0]} :
                strb == STRB_HALF ? {{16{is_signed & s[15]}}, s[15:0]} : s;
endmodule

// File: rtl/mem_access.sv
// mem_access: cushion bundle in, req/ack data bus for loads/stores, registered WB_* commit bundle out, MMU_WAIT stall back upstream
module mem_access
  import mem_access_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  output logic        MMU_WAIT,
  input  logic        CUSHION_VALID,
  input  logic [31:0] CUSHION_PC,
  input  logic        CUSHION_REG_W_EN,
  input  logic [4:0]  CUSHION_REG_W_RD,
  input  logic [31:0] CUSHION_REG_W_DATA,
  input  logic        CUSHION_CSR_W_EN,
  input  logic [11:0] CUSHION_CSR_W_ADDR,
  input  logic [31:0] CUSHION_CSR_W_DATA,
  input  logic        CUSHION_MEM_R_EN,
  input  logic [4:0]  CUSHION_MEM_R_RD,
  input  logic [31:0] CUSHION_MEM_R_ADDR,
  input  logic [3:0]  CUSHION_MEM_R_STRB,
  input  logic        CUSHION_MEM_R_SIGNED,
  input  logic        CUSHION_MEM_W_EN,
  input  logic [31:0] CUSHION_MEM_W_ADDR,
  input  logic [3:0]  CUSHION_MEM_W_STRB,
  input  logic [31:0] CUSHION_MEM_W_DATA,
  input  logic        CUSHION_JMP_DO,
  input  logic [31:0] CUSHION_JMP_PC,
  input  logic        CUSHION_CHMODE_DO,
  input  logic [1:0]  CUSHION_CHMODE_TO,
  input  logic        CUSHION_EXC_EN,
  input  logic [3:0]  CUSHION_EXC_CODE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_FAULT,
  output logic        WB_VALID,
  output logic [31:0] WB_PC,
  output logic        WB_REG_W_EN,
  output logic [4:0]  WB_REG_W_RD,
  output logic [31:0] WB_REG_W_DATA,
  output logic        WB_CSR_W_EN,
  output logic [11:0] WB_CSR_W_ADDR,
  output logic [31:0] WB_CSR_W_DATA,
  output logic        WB_JMP_DO,
  output logic [31:0] WB_JMP_PC,
  output logic        WB_CHMODE_DO,
  output logic [1:0]  WB_CHMODE_TO,
  output logic        WB_EXC_EN,
  output logic [3:0]  WB_EXC_CODE,
  output logic [31:0] WB_EXC_PC
);
  state_t state, state_n;
  wb_t wb, wb_n;
  logic [31:0] cnt, pc_q, a, ld_data;
  logic [4:0] ld_rd;
  logic [3:0] wid, w;
  logic [1:0] lo;
  logic ld, sgn, pend, ld_in, mem_op, mis, trap, start, busy, to, done, bad;
  assign ld_in = CUSHION_MEM_R_EN;
  assign mem_op = CUSHION_MEM_R_EN | CUSHION_MEM_W_EN;
  assign a = ld_in ? CUSHION_MEM_R_ADDR : CUSHION_MEM_W_ADDR;
  assign w = norm_strb(ld_in ? CUSHION_MEM_R_STRB : CUSHION_MEM_W_STRB);
  assign mis = mem_op & misaligned(w, a[1:0]);
  assign trap = CUSHION_EXC_EN | mis;
  assign busy = state != IDLE;
  assign start = RST_N & !busy & CUSHION_VALID & !trap & mem_op & !FLUSH;
  assign to = TIMEOUT != 32'd0 && cnt == TIMEOUT;
  assign done = busy & (MEM_ACK | to);
  assign bad = MEM_ACK ? MEM_FAULT : 1'b1;
  assign MMU_WAIT = start | (busy & !done);
  load_align u_align (.rdata(MEM_RDATA), .addr(lo), .strb(wid), .is_signed(sgn), .data(ld_data));
  always_comb begin
    state_n = state;
    if (start) state_n = ld_in ? RD : WR;
    else if (done) state_n = IDLE;
  end
  always_comb begin
    wb_n = '0;
    if (!busy && CUSHION_VALID && !FLUSH && !start) begin
      wb_n.valid = 1'b1;
      wb_n.pc = CUSHION_PC;
      wb_n.reg_w_en = CUSHION_REG_W_EN & !trap;
      wb_n.reg_w_rd = CUSHION_REG_W_RD;
      wb_n.reg_w_data = CUSHION_REG_W_DATA;
      wb_n.csr_w_en = CUSHION_CSR_W_EN & !trap;
      wb_n.csr_w_addr = CUSHION_CSR_W_ADDR;
      wb_n.csr_w_data = CUSHION_CSR_W_DATA;
      wb_n.jmp_do = CUSHION_JMP_DO & !trap;
      wb_n.jmp_pc = CUSHION_JMP_PC;
      wb_n.chmode_do = CUSHION_CHMODE_DO & !trap;
      wb_n.chmode_to = CUSHION_CHMODE_TO;
      wb_n.exc_en = trap;
      wb_n.exc_code = !trap ? 4'd0 : CUSHION_EXC_EN ? CUSHION_EXC_CODE : ld_in ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
      wb_n.exc_pc = trap ? CUSHION_PC : 32'd0;
    end else if (done && !pend && !FLUSH) begin
      wb_n.valid = 1'b1;
      wb_n.pc = pc_q;
      wb_n.reg_w_en = ld & !bad;
      wb_n.reg_w_rd = (ld & !bad) ? ld_rd : 5'd0;
      wb_n.reg_w_data = (ld & !bad) ? ld_data : 32'd0;
      wb_n.exc_en = bad;
      wb_n.exc_code = !bad ? 4'd0 : ld ? EXC_LD_FAULT : EXC_ST_FAULT;
      wb_n.exc_pc = bad ? pc_q : 32'd0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      wb <= '0;
      cnt <= '0;
      pend <= 1'b0;
      {MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA} <= '0;
      {ld, ld_rd, lo, wid, sgn, pc_q} <= '0;
    end else begin
      state <= state_n;
      wb <= wb_n;
      cnt <= start ? 32'd0 : (busy && !done && cnt != '1) ? cnt + 32'd1 : cnt;
      pend <= busy & !done & (pend | FLUSH);
      if (start) begin
        MEM_REQ <= 1'b1;
        MEM_WE <= !ld_in;
        MEM_ADDR <= {a[31:2], 2'b00};
        MEM_STRB <= w << a[1:0];
        MEM_WDATA <= ld_in ? 32'd0 : CUSHION_MEM_W_DATA << {a[1:0], 3'b000};
        ld <= ld_in;
        ld_rd <= CUSHION_MEM_R_RD;
        lo <= a[1:0];
        wid <= w;
        sgn <= CUSHION_MEM_R_SIGNED;
        pc_q <= CUSHION_PC;
      end else if (done) begin
        {MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA} <= '0;
      end
    end
  end
  assign WB_VALID = wb.valid;
  assign WB_PC = wb.pc;
  assign WB_REG_W_EN = wb.reg_w_en;
  assign WB_REG_W_RD = wb.reg_w_rd;
  assign WB_REG_W_DATA = wb.reg_w_data;
  assign WB_CSR_W_EN = wb.csr_w_en;
  assign WB_CSR_W_ADDR = wb.csr_w_addr;
  assign WB_CSR_W_DATA = wb.csr_w_data;
  assign WB_JMP_DO = wb.jmp_do;
  assign WB_JMP_PC = wb.jmp_pc;
  assign WB_CHMODE_DO = wb.chmode_do;
  assign WB_CHMODE_TO = wb.chmode_to;
  assign WB_EXC_EN = wb.exc_en;
  assign WB_EXC_CODE = wb.exc_code;
  assign WB_EXC_PC = wb.exc_pc;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed self-checking bench for mem_access against a behavioural model
module tb_mem_access;
  localparam logic [31:0] TO = 32'd4;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N, FLUSH, MMU_WAIT;
  logic CUSHION_VALID, CUSHION_REG_W_EN, CUSHION_CSR_W_EN, CUSHION_MEM_R_EN, CUSHION_MEM_R_SIGNED;
  logic CUSHION_MEM_W_EN, CUSHION_JMP_DO, CUSHION_CHMODE_DO, CUSHION_EXC_EN;
  logic [31:0] CUSHION_PC, CUSHION_REG_W_DATA, CUSHION_CSR_W_DATA, CUSHION_MEM_R_ADDR;
  logic [31:0] CUSHION_MEM_W_ADDR, CUSHION_MEM_W_DATA, CUSHION_JMP_PC;
  logic [4:0] CUSHION_REG_W_RD, CUSHION_MEM_R_RD;
  logic [11:0] CUSHION_CSR_W_ADDR;
  logic [3:0] CUSHION_MEM_R_STRB, CUSHION_MEM_W_STRB, CUSHION_EXC_CODE;
  logic [1:0] CUSHION_CHMODE_TO;
  logic MEM_REQ, MEM_WE, MEM_ACK, MEM_FAULT;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [3:0] MEM_STRB;
  logic WB_VALID, WB_REG_W_EN, WB_CSR_W_EN, WB_JMP_DO, WB_CHMODE_DO, WB_EXC_EN;
  logic [31:0] WB_PC, WB_REG_W_DATA, WB_CSR_W_DATA, WB_JMP_PC, WB_EXC_PC;
  logic [4:0] WB_REG_W_RD;
  logic [11:0] WB_CSR_W_ADDR;
  logic [1:0] WB_CHMODE_TO;
  logic [3:0] WB_EXC_CODE;

  mem_access #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
    .CUSHION_VALID(CUSHION_VALID), .CUSHION_PC(CUSHION_PC),
    .CUSHION_REG_W_EN(CUSHION_REG_W_EN), .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
    .CUSHION_CSR_W_EN(CUSHION_CSR_W_EN), .CUSHION_CSR_W_ADDR(CUSHION_CSR_W_ADDR), .CUSHION_CSR_W_DATA(CUSHION_CSR_W_DATA),
    .CUSHION_MEM_R_EN(CUSHION_MEM_R_EN), .CUSHION_MEM_R_RD(CUSHION_MEM_R_RD), .CUSHION_MEM_R_ADDR(CUSHION_MEM_R_ADDR),
    .CUSHION_MEM_R_STRB(CUSHION_MEM_R_STRB), .CUSHION_MEM_R_SIGNED(CUSHION_MEM_R_SIGNED),
    .CUSHION_MEM_W_EN(CUSHION_MEM_W_EN), .CUSHION_MEM_W_ADDR(CUSHION_MEM_W_ADDR), .CUSHION_MEM_W_STRB(CUSHION_MEM_W_STRB),
    .CUSHION_MEM_W_DATA(CUSHION_MEM_W_DATA), .CUSHION_JMP_DO(CUSHION_JMP_DO), .CUSHION_JMP_PC(CUSHION_JMP_PC),
    .CUSHION_CHMODE_DO(CUSHION_CHMODE_DO), .CUSHION_CHMODE_TO(CUSHION_CHMODE_TO),
    .CUSHION_EXC_EN(CUSHION_EXC_EN), .CUSHION_EXC_CODE(CUSHION_EXC_CODE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .MEM_FAULT(MEM_FAULT),
    .WB_VALID(WB_VALID), .WB_PC(WB_PC),
    .WB_REG_W_EN(WB_REG_W_EN), .WB_REG_W_RD(WB_REG_W_RD), .WB_REG_W_DATA(WB_REG_W_DATA),
    .WB_CSR_W_EN(WB_CSR_W_EN), .WB_CSR_W_ADDR(WB_CSR_W_ADDR), .WB_CSR_W_DATA(WB_CSR_W_DATA),
    .WB_JMP_DO(WB_JMP_DO), .WB_JMP_PC(WB_JMP_PC), .WB_CHMODE_DO(WB_CHMODE_DO), .WB_CHMODE_TO(WB_CHMODE_TO),
    .WB_EXC_EN(WB_EXC_EN), .WB_EXC_CODE(WB_EXC_CODE), .WB_EXC_PC(WB_EXC_PC)
  );

  int n_cmp = 0, n_bad = 0;
  logic e_valid;
  logic [31:0] e_pc;
  logic [37:0] e_reg;
  logic [44:0] e_csr;
  logic [32:0] e_jmp;
  logic [2:0] e_chm;
  logic [36:0] e_exc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_wb();
    check("wb_valid", 64'(WB_VALID), 64'(e_valid));
    check("wb_pc", 64'(WB_PC), 64'(e_pc));
    check("wb_reg", 64'({WB_REG_W_EN, WB_REG_W_RD, WB_REG_W_DATA}), 64'(e_reg));
    check("wb_csr", 64'({WB_CSR_W_EN, WB_CSR_W_ADDR, WB_CSR_W_DATA}), 64'(e_csr));
    check("wb_jmp", 64'({WB_JMP_DO, WB_JMP_PC}), 64'(e_jmp));
    check("wb_chmode", 64'({WB_CHMODE_DO, WB_CHMODE_TO}), 64'(e_chm));
    check("wb_exc", 64'({WB_EXC_EN, WB_EXC_CODE, WB_EXC_PC}), 64'(e_exc));
  endtask

  function automatic logic [31:0] ld_value(input logic [31:0] word, input int lo, input int width, input bit sg);
    longint v, m;
    v = longint'({32'd0, word}) >> (8 * lo);
    m = longint'(1) << (8 * width);
    v = v % m;
    if (sg && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic logic [3:0] rand_strb();
    int r = $urandom_range(0, 4);
    return r == 0 ? 4'd1 : r == 1 ? 4'd3 : r == 2 ? 4'd15 : 4'($urandom);
  endfunction

  task automatic clear_bundle();
    {CUSHION_VALID, CUSHION_PC, CUSHION_REG_W_EN, CUSHION_REG_W_RD, CUSHION_REG_W_DATA} = '0;
    {CUSHION_CSR_W_EN, CUSHION_CSR_W_ADDR, CUSHION_CSR_W_DATA, CUSHION_JMP_DO, CUSHION_JMP_PC} = '0;
    {CUSHION_MEM_R_EN, CUSHION_MEM_R_RD, CUSHION_MEM_R_ADDR, CUSHION_MEM_R_STRB, CUSHION_MEM_R_SIGNED} = '0;
    {CUSHION_MEM_W_EN, CUSHION_MEM_W_ADDR, CUSHION_MEM_W_STRB, CUSHION_MEM_W_DATA} = '0;
    {CUSHION_CHMODE_DO, CUSHION_CHMODE_TO, CUSHION_EXC_EN, CUSHION_EXC_CODE, FLUSH} = '0;
  endtask

  task automatic rand_bundle(input int kind);
    CUSHION_VALID = kind != 4;
    CUSHION_PC = $urandom;
    CUSHION_REG_W_EN = 1'($urandom);
    CUSHION_REG_W_RD = 5'($urandom);
    CUSHION_REG_W_DATA = $urandom;
    CUSHION_CSR_W_EN = 1'($urandom);
    CUSHION_CSR_W_ADDR = 12'($urandom);
    CUSHION_CSR_W_DATA = $urandom;
    CUSHION_JMP_DO = 1'($urandom);
    CUSHION_JMP_PC = $urandom;
    CUSHION_CHMODE_DO = 1'($urandom);
    CUSHION_CHMODE_TO = 2'($urandom);
    CUSHION_EXC_EN = kind == 3;
    CUSHION_EXC_CODE = 4'($urandom);
    CUSHION_MEM_R_EN = kind == 1 || kind == 5 || (kind == 3 && $urandom_range(0, 1) == 1);
    CUSHION_MEM_W_EN = kind == 2 || (kind == 1 && $urandom_range(0, 3) == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
    CUSHION_MEM_R_RD = 5'($urandom);
    CUSHION_MEM_R_ADDR = $urandom;
    CUSHION_MEM_R_STRB = rand_strb();
    CUSHION_MEM_R_SIGNED = 1'($urandom);
    CUSHION_MEM_W_ADDR = $urandom;
    CUSHION_MEM_W_STRB = rand_strb();
    CUSHION_MEM_W_DATA = $urandom;
    FLUSH = $urandom_range(0, 9) == 0;
  endtask

  // Called right after the bundle has been driven at a falling edge; models one full transaction.
  task automatic exec(input int lat, input bit flt, input logic [31:0] rdat);
    bit ld, mem, mis, go, trap;
    int width, lo, es;
    logic [31:0] a, ew;
    logic [3:0] s;
    ld = CUSHION_MEM_R_EN;
    mem = CUSHION_MEM_R_EN || CUSHION_MEM_W_EN;
    a = ld ? CUSHION_MEM_R_ADDR : CUSHION_MEM_W_ADDR;
    s = ld ? CUSHION_MEM_R_STRB : CUSHION_MEM_W_STRB;
    width = s == 4'd1 ? 1 : s == 4'd3 ? 2 : 4;
    lo = int'(a % 4);
    mis = mem && (lo + width > 4);
    go = CUSHION_VALID && !CUSHION_EXC_EN && mem && !mis && !FLUSH;
    {e_valid, e_pc, e_reg, e_csr, e_jmp, e_chm, e_exc} = '0;
    #1 check("mmu_wait_start", 64'(MMU_WAIT), 64'(go));
    if (!go) begin
      if (CUSHION_VALID && !FLUSH) begin
        trap = CUSHION_EXC_EN || mis;
        e_valid = 1'b1;
        e_pc = CUSHION_PC;
        e_reg = {CUSHION_REG_W_EN && !trap, CUSHION_REG_W_RD, CUSHION_REG_W_DATA};
        e_csr = {CUSHION_CSR_W_EN && !trap, CUSHION_CSR_W_ADDR, CUSHION_CSR_W_DATA};
        e_jmp = {CUSHION_JMP_DO && !trap, CUSHION_JMP_PC};
        e_chm = {CUSHION_CHMODE_DO && !trap, CUSHION_CHMODE_TO};
        if (trap) e_exc = {1'b1, CUSHION_EXC_EN ? CUSHION_EXC_CODE : (ld ? 4'd4 : 4'd6), CUSHION_PC};
      end
      @(posedge CLK); #1;
      check("no_req", 64'(MEM_REQ), 64'(0));
      check_wb();
    end else begin
      @(posedge CLK); #1;
      es = ((1 << width) - 1) << lo;
      ew = CUSHION_MEM_W_DATA << (8 * lo);
      check("req_we", 64'({MEM_REQ, MEM_WE}), 64'({1'b1, !ld}));
      check("mem_addr", 64'(MEM_ADDR), 64'(a - 32'(lo)));
      check("mem_strb", 64'(MEM_STRB), 64'(es));
      if (!ld) check("mem_wdata", 64'(MEM_WDATA), 64'(ew));
      repeat (lat) begin
        @(negedge CLK); #1;
        check("mmu_wait_busy", 64'({MMU_WAIT, MEM_REQ}), 64'(2'b11));
      end
      @(negedge CLK);
      MEM_ACK = 1'b1;
      MEM_RDATA = rdat;
      MEM_FAULT = flt;
      #1 check("mmu_wait_ack", 64'(MMU_WAIT), 64'(0));
      e_valid = 1'b1;
      e_pc = CUSHION_PC;
      if (flt) e_exc = {1'b1, ld ? 4'd5 : 4'd7, CUSHION_PC};
      else if (ld) e_reg = {1'b1, CUSHION_MEM_R_RD, ld_value(rdat, lo, width, CUSHION_MEM_R_SIGNED)};
      @(posedge CLK); #1;
      check_wb();
      check("req_drop", 64'(MEM_REQ), 64'(0));
      @(negedge CLK);
      {MEM_ACK, MEM_FAULT, CUSHION_VALID} = '0;
    end
  endtask

  initial begin
    RST_N = 1'b0;
    clear_bundle();
    {MEM_ACK, MEM_FAULT, MEM_RDATA} = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wb_valid", 64'(WB_VALID), 64'(0));
    check("rst_mem", 64'({MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA}), 64'(0));
    check("rst_mmu_wait", 64'(MMU_WAIT), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    // ALU result passes straight through
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h100; CUSHION_REG_W_EN = 1'b1;
    CUSHION_REG_W_RD = 5'd5; CUSHION_REG_W_DATA = 32'h1234;
    exec(0, 1'b0, 32'd0);
    check("alu_data", 64'(WB_REG_W_DATA), 64'h1234);
    // Signed byte load from the top lane
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h104; CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_RD = 5'd7;
    CUSHION_MEM_R_ADDR = 32'h1003; CUSHION_MEM_R_STRB = 4'b0001; CUSHION_MEM_R_SIGNED = 1'b1;
    exec(3, 1'b0, 32'h80123456);
    check("lb_data", 64'(WB_REG_W_DATA), 64'hFFFFFF80);
    // Half store to the upper lanes
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h108; CUSHION_MEM_W_EN = 1'b1;
    CUSHION_MEM_W_ADDR = 32'h2002; CUSHION_MEM_W_STRB = 4'b0011; CUSHION_MEM_W_DATA = 32'hBEEF;
    exec(1, 1'b0, 32'd0);
    // Misaligned word load traps without a bus access
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h10C; CUSHION_MEM_R_EN = 1'b1;
    CUSHION_MEM_R_ADDR = 32'h3001; CUSHION_MEM_R_STRB = 4'b1111;
    exec(0, 1'b0, 32'd0);
    check("mis_code", 64'({WB_EXC_EN, WB_EXC_CODE}), 64'h14);
    // Bus fault on a load
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h110; CUSHION_MEM_R_EN = 1'b1;
    CUSHION_MEM_R_ADDR = 32'h40; CUSHION_MEM_R_STRB = 4'b1111;
    exec(2, 1'b1, 32'hDEAD_BEEF);
    // Timeout: no ACK ever arrives
    @(negedge CLK);
    clear_bundle();
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h114; CUSHION_MEM_R_EN = 1'b1;
    CUSHION_MEM_R_ADDR = 32'h44; CUSHION_MEM_R_STRB = 4'b1111;
    @(posedge CLK); #1;
    check("to_req", 64'(MEM_REQ), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      check("to_wait", 64'({MMU_WAIT, MEM_REQ}), 64'(2'b11));
    end
    @(negedge CLK); #1;
    check("to_release", 64'(MMU_WAIT), 64'(0));
    @(posedge CLK); #1;
    check("to_trap", 64'({WB_VALID, WB_REG_W_EN, WB_EXC_EN, WB_EXC_CODE, WB_EXC_PC}), 64'({3'b101, 4'd5, 32'h114}));
    check("to_req_drop", 64'(MEM_REQ), 64'(0));
    // Flush while the load is outstanding, ACK two cycles later
    @(negedge CLK);
    CUSHION_PC = 32'h118; CUSHION_MEM_R_ADDR = 32'h48;
    @(posedge CLK); #1;
    @(negedge CLK); FLUSH = 1'b1;
    #1 check("fl_wait", 64'(MMU_WAIT), 64'(1));
    @(negedge CLK); FLUSH = 1'b0;
    @(negedge CLK); MEM_ACK = 1'b1; MEM_RDATA = 32'h55;
    @(posedge CLK); #1;
    check("fl_discard", 64'({WB_VALID, WB_REG_W_EN, MEM_REQ}), 64'(0));
    @(negedge CLK); MEM_ACK = 1'b0; CUSHION_VALID = 1'b0;
    #1 check("fl_idle", 64'(MMU_WAIT), 64'(0));
    // FLUSH coincident with ACK
    @(negedge CLK);
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h11C;
    @(posedge CLK); #1;
    @(negedge CLK); MEM_ACK = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1;
    check("flack_discard", 64'(WB_VALID), 64'(0));
    @(negedge CLK); {MEM_ACK, FLUSH, CUSHION_VALID} = '0;
    // Reset in the middle of a load
    @(negedge CLK);
    CUSHION_VALID = 1'b1; CUSHION_PC = 32'h120;
    @(posedge CLK); #1;
    @(negedge CLK); RST_N = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid", 64'({MEM_REQ, MMU_WAIT, WB_VALID}), 64'(0));
    @(negedge CLK); RST_N = 1'b1; CUSHION_VALID = 1'b0;
    // Randomized mix of every bundle kind
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      rand_bundle($urandom_range(0, 5));
      exec($urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Consumer end of the cushion bundle. Takes the merged main/cop result and performs any load or store on a simple request/ack data bus.
- Produces the registered writeback/commit bundle: register, CSR, jump, mode change and trap.
- Drives MMU_WAIT back upstream so the cushion holds its registered bundle while a bus access is outstanding.

Parameters:
- TIMEOUT, 32'd256, bus cycles to wait for MEM_ACK before raising an access fault; 0 disables the timeout.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- FLUSH  in  1  pipeline flush
- MMU_WAIT  out  1  stall request to cushion and earlier stages
- CUSHION_*  in  (widths per bundle)  VALID, PC[31:0], REG_W_EN/RD[4:0]/DATA[31:0], CSR_W_EN/ADDR[11:0]/DATA[31:0], MEM_R_EN/RD[4:0]/ADDR[31:0]/STRB[3:0]/SIGNED, MEM_W_EN/ADDR[31:0]/STRB[3:0]/DATA[31:0], JMP_DO/PC[31:0], CHMODE_DO/TO[1:0], EXC_EN/CODE[3:0]
- MEM_REQ  out  1  bus request, held until MEM_ACK
- MEM_WE  out  1  1=store
- MEM_ADDR  out  32  word-aligned address
- MEM_STRB  out  4  byte lanes
- MEM_WDATA  out  32  lane-shifted store data
- MEM_ACK  in  1  bus completion
- MEM_RDATA  in  32  read word, valid with MEM_ACK
- MEM_FAULT  in  1  bus error, valid with MEM_ACK
- WB_VALID  out  1  commit bundle valid
- WB_PC  out  32  committed PC
- WB_REG_W_EN/RD/DATA  out  1/5/32  GPR write
- WB_CSR_W_EN/ADDR/DATA  out  1/12/32  CSR write
- WB_JMP_DO/PC  out  1/32  redirect
- WB_CHMODE_DO/TO  out  1/2  privilege change
- WB_EXC_EN/CODE/PC  out  1/4/32  trap request

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - state=IDLE, timeout counter=0.
  - All WB_* and MEM_* outputs are 0.
  - MMU_WAIT=0 from the first cycle after reset.
  - An outstanding bus request is dropped; the bus slave tolerates REQ deasserting.
- STRB encoding is an unshifted width mask: 0001 byte, 0011 half, 1111 word. Any other value is treated as word.
- Misalignment: half with addr[1:0]=3, or word with addr[1:0]!=0. This raises exception code 4 (load) or 6 (store) with no bus access.
- States are IDLE, RD, WR.
- IDLE, entry condition: CUSHION_VALID & !CUSHION_EXC_EN & (MEM_R_EN | MEM_W_EN) & aligned.
  - MMU_WAIT=1 combinationally.
  - Next state is RD if MEM_R_EN, else WR. R_EN has priority when both are set; W is ignored.
  - MEM_REQ, MEM_ADDR={addr[31:2],2'b00}, MEM_STRB=strb<<addr[1:0], MEM_WDATA=data<<(8*addr[1:0]) are registered and appear the next cycle.
- IDLE, otherwise: the bundle is registered to WB_* with 1-cycle latency and MMU_WAIT=0.
  - A misaligned access or CUSHION_EXC_EN commits as a trap: WB_EXC_EN=1, WB_EXC_PC=CUSHION_PC, and REG/CSR/JMP/CHMODE enables forced to 0.
- RD/WR:
  - MMU_WAIT=1 and MEM_REQ=1 until MEM_ACK; the counter increments each waiting cycle.
  - On MEM_ACK without fault: return to IDLE, MMU_WAIT=0 that same cycle, and WB_VALID=1 on the next edge.
    - Load: WB_REG_W_EN=1, RD=MEM_R_RD, DATA=(RDATA>>8*addr[1:0]) masked to width, sign-extended when SIGNED.
    - Store: WB_REG_W_EN=0.
  - On MEM_FAULT, or counter==TIMEOUT (TIMEOUT!=0): trap with code 5 (load) or 7 (store), and REG_W_EN=0.
    - On timeout, MEM_REQ drops the next cycle.
- WB_VALID=0 implies all WB_* are 0.
- CUSHION_VALID=0 in IDLE produces WB_VALID=0 the next cycle.
- FLUSH:
  - In IDLE: WB_* are cleared the next cycle and no access starts.
  - In RD/WR: a pending-flush flag is set and the access runs to ACK/fault/timeout. The result is discarded (WB_VALID=0), then IDLE.
  - Simultaneous FLUSH and ACK: the result is discarded.
- Counter width is 32 bits and resets on every new access. It saturates and never wraps.

Decomposition:
- Shared package mem_access_pkg:
  - state encodings IDLE/RD/WR
  - STRB_BYTE/HALF/WORD constants
  - exception codes 4/5/6/7
- One combinational sub-module, load_align: inputs rdata, addr[1:0], strb, signed; output data[31:0]. It handles lane extraction and sign extension.

Test Plan:
- ALU bundle VALID=1, REG_W_EN=1, RD=5, DATA=0x1234 -> next cycle WB_VALID=1, RD=5, DATA=0x1234, MMU_WAIT stays 0.
- Load byte, addr=0x1003, SIGNED=1, RDATA=0x80xxxxxx, ACK after 3 cycles:
  - MMU_WAIT high for 4 cycles.
  - MEM_ADDR=0x1000, MEM_STRB=1000.
  - WB_REG_W_DATA=0xFFFFFF80.
- Store half, addr=0x2002, DATA=0xBEEF -> MEM_WE=1, MEM_STRB=1100, MEM_WDATA=0xBEEF0000; after ACK, WB_VALID=1, WB_REG_W_EN=0.
- Load word at addr=0x3001 -> no MEM_REQ; WB_EXC_EN=1, CODE=4, EXC_PC=CUSHION_PC.
- Load with MEM_ACK+MEM_FAULT -> CODE=5; with TIMEOUT=4 and no ACK -> CODE=5 after 4 wait cycles, MEM_REQ then 0.
- FLUSH during RD, ACK two cycles later -> WB_VALID=0, state IDLE; RST_N=0 mid-RD -> MEM_REQ=0 and MMU_WAIT=0 next cycle.
